instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifu_pkg.sv | 26 ++
 rtl/ifu_fifo.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, the buffered fetch-entry layout and the PC step size.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FAULT
    } ifu_state_e;

    localparam int unsigned PC_INCR       = 4;
    localparam int unsigned ENTRY_PC_W    = 32;
    localparam int unsigned ENTRY_INSTR_W = 32;

    // Layout of one buffered fetch result at the default 32-bit widths.
    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer: power-of-two depth FIFO with occupancy count and a
// synchronous flush that takes priority over push and pop.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; empty/count gate every read, so its contents never matter until written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = count_q == CNT_W'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited single-outstanding fetcher feeding a
// PC-tagged buffer. Define IFU_PERF_CNT_EN to add saturating perf counters.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fetch_fault
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    typedef logic [CNT_W:0] occ_t;
    localparam occ_t DEPTH_OCC = occ_t'(FIFO_DEPTH);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              discard_q, discard_d;
    logic              fault_q, fault_d;

    logic              resp_ok;
    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;
    occ_t              occ_next;
    logic              credit_next;

    ifu_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        fault_d    = fault_q;
        fifo_flush = 1'b0;

        resp_ok   = (state_q == S_WAIT) && imem_rvalid && !discard_q && !redirect;
        fifo_pop  = out_valid && out_ready && !redirect;
        fifo_push = resp_ok && (!fifo_full || fifo_pop);

        // Occupancy after this edge's push/pop; a new request claims one more slot.
        occ_next    = occ_t'(fifo_count) + occ_t'(fifo_push) - occ_t'(fifo_pop);
        credit_next = occ_next < DEPTH_OCC;

        case (state_q)
            S_IDLE: begin
                if (credit_next) state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(PC_INCR);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    discard_d = 1'b0;
                    state_d   = credit_next ? S_REQ : S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
        endcase

        // A response already accepted by memory must still be absorbed, so a
        // granted or in-flight request keeps the FSM in WAIT with discard set.
        if (redirect && state_q != S_FAULT) begin
            fifo_flush = 1'b1;
            if (is_misaligned(redirect_pc[1:0])) begin
                state_d   = S_FAULT;
                fault_d   = 1'b1;
                discard_d = 1'b0;
            end else begin
                pc_d = redirect_pc;
                if ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && imem_gnt)) begin
                    state_d   = S_WAIT;
                    discard_d = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            discard_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_req    = state_q == S_REQ;
    assign imem_addr   = pc_q;
    assign out_valid   = !fifo_empty && state_q != S_FAULT;
    assign out_instr   = fifo_rdata[INSTR_W-1:0];
    assign out_pc      = fifo_rdata[ENTRY_W-1:INSTR_W];
    assign fetch_fault = fault_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    occ_t        occ_now;

    assign occ_now = occ_t'(fifo_count) + occ_t'((state_q == S_REQ || state_q == S_WAIT) && !discard_q);

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (fifo_push && perf_fetched_q != '1) perf_fetched_d = perf_fetched_q + 32'd1;
        if (occ_now >= DEPTH_OCC && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
